// File: rtl/la_vdist4.sv
// One-hot steered 1-to-4 stream distributor with one register slot per output channel.
// Optional feature: define LA_VDIST4_RR_EN to treat an all-zero select as round-robin "any channel".
module la_vdist4 #(
    parameter int N    = 1,
    parameter     PROP = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sel3,
    input  logic         sel2,
    input  logic         sel1,
    input  logic         sel0,
    input  logic [N-1:0] in,
    input  logic         err_clear,
    output logic [N-1:0] out3,
    output logic [N-1:0] out2,
    output logic [N-1:0] out1,
    output logic [N-1:0] out0,
    output logic         valid3,
    output logic         valid2,
    output logic         valid1,
    output logic         valid0,
    input  logic         ready3,
    input  logic         ready2,
    input  logic         ready1,
    input  logic         ready0,
    output logic         err
);

    logic [3:0]   sel;
    logic [3:0]   rdy;
    logic [3:0]   free;
    logic [3:0]   tgt;
    logic [3:0]   load;
    logic         onehot;
    logic         legal;
    logic         xfer;
    logic [N-1:0] data_p1 [4];
    logic [3:0]   vld_p1;
    logic         err_p1;

    // Cell property hook for technology mapping; no logic depends on it.
    if (PROP != "DEFAULT") begin : g_prop
    end

    assign sel    = {sel3, sel2, sel1, sel0};
    assign rdy    = {ready3, ready2, ready1, ready0};
    assign free   = ~vld_p1 | rdy;
    assign onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);

`ifdef LA_VDIST4_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] rr_idx;
    logic [1:0] rr_cand;
    logic [3:0] rr_gnt;
    logic       rr_hit;

    // First free channel searching upward from the pointer, wrapping mod 4.
    always_comb begin
        rr_gnt  = 4'd0;
        rr_idx  = 2'd0;
        rr_cand = 2'd0;
        rr_hit  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rr_cand = rr_ptr + 2'(i);
            if (!rr_hit && free[rr_cand]) begin
                rr_gnt[rr_cand] = 1'b1;
                rr_idx          = rr_cand;
                rr_hit          = 1'b1;
            end
        end
    end

    assign legal = onehot || (sel == 4'd0);
    assign tgt   = onehot ? sel : rr_gnt;

    always_ff @(posedge clk) begin
        if (!nreset)
            rr_ptr <= 2'd0;
        else if (in_valid && in_ready && (sel == 4'd0))
            rr_ptr <= rr_idx + 2'd1;
    end
`else
    assign legal = onehot;
    assign tgt   = sel;
`endif

    // Illegal selects are always accepted so a bad word cannot wedge the stream.
    assign in_ready = legal ? |(tgt & free) : 1'b1;
    assign xfer     = in_valid && in_ready;
    assign load     = (xfer && legal) ? tgt : 4'd0;

    // ---- stage p1: channel slots and sticky error ----
    always_ff @(posedge clk) begin
        if (!nreset) begin
            vld_p1 <= 4'd0;
            err_p1 <= 1'b0;
            for (int k = 0; k < 4; k++)
                data_p1[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_p1[k] <= in;
                    vld_p1[k]  <= 1'b1;
                end else if (rdy[k]) begin
                    vld_p1[k]  <= 1'b0;
                end
            end
            if (xfer && !legal)
                err_p1 <= 1'b1;
            else if (err_clear)
                err_p1 <= 1'b0;
        end
    end

    assign out0   = data_p1[0];
    assign out1   = data_p1[1];
    assign out2   = data_p1[2];
    assign out3   = data_p1[3];
    assign valid0 = vld_p1[0];
    assign valid1 = vld_p1[1];
    assign valid2 = vld_p1[2];
    assign valid3 = vld_p1[3];
    assign err    = err_p1;

endmodule

// File: tb/tb_la_vdist4.sv
// Directed self-checking bench for la_vdist4 (N=8); follows LA_VDIST4_RR_EN if defined.
module tb_la_vdist4;

    logic       clk = 1'b0;
    logic       nreset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sel;
    logic [7:0] din;
    logic       err_clear;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] vld;
    logic [3:0] rdy;
    logic       err;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    la_vdist4 #(.N(8), .PROP("DEFAULT")) dut (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
        .sel3(sel[3]), .sel2(sel[2]), .sel1(sel[1]), .sel0(sel[0]),
        .in(din), .err_clear(err_clear),
        .out3(out3), .out2(out2), .out1(out1), .out0(out0),
        .valid3(vld[3]), .valid2(vld[2]), .valid1(vld[1]), .valid0(vld[0]),
        .ready3(rdy[3]), .ready2(rdy[2]), .ready1(rdy[1]), .ready0(rdy[0]),
        .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; in_valid = 1'b0; sel = 4'd0; din = 8'd0; err_clear = 1'b0; rdy = 4'd0;
        tick(); tick();
        nreset = 1'b1;
        tick();
        checks++; if (vld !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", vld); end
        checks++; if ({out3, out2, out1, out0} !== 32'd0) begin errors++; $display("FAIL reset_out: got %h expected 00000000", {out3, out2, out1, out0}); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        sel = 4'b0001; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_load_hold();
        din = 8'hA5; sel = 4'b0010; in_valid = 1'b1; rdy = 4'd0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0; din = 8'h00;
        checks++; if (vld !== 4'b0010) begin errors++; $display("FAIL load_valid: got %b expected 0010", vld); end
        checks++; if (out1 !== 8'hA5) begin errors++; $display("FAIL load_out1: got %h expected a5", out1); end
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL held_ready_sel1: got %b expected 0", in_ready); end
        sel = 4'b0100; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL held_ready_sel2: got %b expected 1", in_ready); end
        tick();
        checks++; if ((out1 !== 8'hA5) || (vld !== 4'b0010)) begin errors++; $display("FAIL hold_stable: got %h/%b expected a5/0010", out1, vld); end
    endtask

    task automatic test_back_to_back();
        rdy = 4'b0010; din = 8'h3C; sel = 4'b0010; in_valid = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ((vld !== 4'b0010) || (out1 !== 8'h3C)) begin errors++; $display("FAIL b2b_reload: got %b/%h expected 0010/3c", vld, out1); end
        tick();
        checks++; if (vld !== 4'b0000) begin errors++; $display("FAIL b2b_drain: got %b expected 0000", vld); end
        rdy = 4'd0;
    endtask

    task automatic test_illegal();
        sel = 4'b1001; din = 8'hFF; in_valid = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ((vld !== 4'b0000) || (err !== 1'b1)) begin errors++; $display("FAIL illegal_err: got %b/%b expected 0000/1", vld, err); end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
        in_valid = 1'b1; err_clear = 1'b1;
        tick();
        in_valid = 1'b0; err_clear = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b expected 1", err); end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    task automatic test_stream();
        rdy = 4'd0;
        for (int k = 0; k < 4; k++) begin
            sel = 4'b0001 << k; din = 8'(k + 1); in_valid = 1'b1; #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b expected 1", k, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (vld !== 4'b1111) begin errors++; $display("FAIL stream_full: got %b expected 1111", vld); end
        repeat (10) tick();
        checks++; if ({vld, out3, out2, out1, out0} !== {4'b1111, 32'h04030201}) begin errors++; $display("FAIL stream_hold: got %b/%h expected 1111/04030201", vld, {out3, out2, out1, out0}); end
        rdy = 4'b0100;
        tick();
        rdy = 4'd0;
        checks++; if ({vld, out3, out1, out0} !== {4'b1011, 24'h040201}) begin errors++; $display("FAIL stream_drain2: got %b/%h expected 1011/040201", vld, {out3, out1, out0}); end
    endtask

    task automatic test_midreset();
        sel = 4'b0011; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        checks++; if ({vld, err} !== 5'b00000) begin errors++; $display("FAIL midreset_ctl: got %b/%b expected 0000/0", vld, err); end
        checks++; if ({out3, out2, out1, out0} !== 32'd0) begin errors++; $display("FAIL midreset_out: got %h expected 00000000", {out3, out2, out1, out0}); end
    endtask

    task automatic test_zero_sel();
        logic [7:0] outs [4];
`ifdef LA_VDIST4_RR_EN
        int exp_ch [5] = '{0, 1, 2, 3, 0};
        int exp_st [4] = '{2, 3, 0, 2};
        rdy = 4'b1111; sel = 4'd0;
        for (int w = 0; w < 5; w++) begin
            din = 8'h10 + 8'(w); in_valid = 1'b1; #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_ready%0d: got %b expected 1", w, in_ready); end
            tick();
            outs = '{out0, out1, out2, out3};
            checks++; if ((vld !== (4'b0001 << exp_ch[w])) || (outs[exp_ch[w]] !== din)) begin errors++; $display("FAIL rr_word%0d: got %b/%h expected ch%0d/%h", w, vld, outs[exp_ch[w]], exp_ch[w], din); end
        end
        in_valid = 1'b0;
        tick();
        rdy = 4'b1101; sel = 4'b0010; din = 8'h20; in_valid = 1'b1;
        tick();
        sel = 4'd0;
        for (int w = 0; w < 4; w++) begin
            din = 8'h21 + 8'(w); #1;
            tick();
            outs = '{out0, out1, out2, out3};
            checks++; if ((vld !== (4'b0010 | (4'b0001 << exp_st[w]))) || (outs[exp_st[w]] !== din)) begin errors++; $display("FAIL rr_skip%0d: got %b/%h expected ch%0d/%h", w, vld, outs[exp_st[w]], exp_st[w], din); end
        end
        in_valid = 1'b0;
        checks++; if ((out1 !== 8'h20) || (err !== 1'b0)) begin errors++; $display("FAIL rr_stall_hold: got %h/%b expected 20/0", out1, err); end
`else
        rdy = 4'b1111; sel = 4'd0;
        for (int w = 0; w < 5; w++) begin
            din = 8'h10 + 8'(w); in_valid = 1'b1; #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready%0d: got %b expected 1", w, in_ready); end
            tick();
            outs = '{out0, out1, out2, out3};
            checks++; if ((vld !== 4'b0000) || (err !== 1'b1)) begin errors++; $display("FAIL zero_drop%0d: got %b/%b expected 0000/1 (out0 %h)", w, vld, err, outs[0]); end
        end
        in_valid = 1'b0;
`endif
        rdy = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_load_hold();
        test_back_to_back();
        test_illegal();
        test_stream();
        test_midreset();
        test_zero_sel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
